// File: rtl/cpu_fetch_pkg.sv
// Shared constants and the queued-entry type for the instruction prefetch stage.
package cpu_fetch_pkg;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;
  localparam int PC_STEP = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for fetched words and for in-flight pc tags.
// Storage resets to zero so an empty queue presents an all-zero head.
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en, pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetch stage: owns the fetch pointer, issues in-order IMEM reads under a
// DEPTH credit cap and queues returned words for decode. FETCH_BYPASS_EN adds a zero-latency empty-queue path.
module instr_fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic                    dec_valid,
  output logic [INSTR_W-1:0]      dec_instr,
  output logic [ADDR_W-1:0]       dec_pc,
  input  logic                    dec_ready,
  output logic [$clog2(DEPTH):0]  q_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              started_q, started_d;
  logic [CW:0]       credit_used;
  logic              issue, resp_keep, resp_drop, bypass;
  logic              data_push, data_pop, data_empty, data_full;
  logic [CW-1:0]     data_count, tag_count;
  logic              tag_empty, tag_full;
  logic [ADDR_W-1:0] tag_head;
  fetch_entry_t      data_in, data_head;

  // Requests already in flight count against queue space so a response always has a slot.
  assign credit_used = {1'b0, data_count} + {1'b0, outstanding_q};
  assign imem_req    = started_q && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_ptr_q;
  assign issue       = imem_req && imem_gnt;
  assign resp_keep   = imem_rvalid && (drop_cnt_q == '0);
  assign resp_drop   = imem_rvalid && (drop_cnt_q != '0);
  assign data_in     = '{instr: imem_rdata, pc: tag_head};

`ifdef FETCH_BYPASS_EN
  assign bypass = data_empty && resp_keep && !redirect;
`else
  assign bypass = 1'b0;
`endif

  // Decode handshake: an instruction moves on a cycle with dec_valid && dec_ready;
  // dec_valid never waits on dec_ready and the offered word holds until taken.
  assign data_push = resp_keep && !(bypass && dec_ready);
  assign data_pop  = dec_ready && !data_empty;
  assign dec_valid = !data_empty || bypass;
  assign dec_instr = bypass ? imem_rdata : data_head.instr;
  assign dec_pc    = bypass ? tag_head : data_head.pc;
  assign q_count   = data_count;

  always_comb begin
    fetch_ptr_d   = fetch_ptr_q;
    drop_cnt_d    = drop_cnt_q;
    started_d     = 1'b1;
    outstanding_d = outstanding_q + CW'(issue)
                  - CW'(imem_rvalid && (outstanding_q != '0));
    if (issue)     fetch_ptr_d = fetch_ptr_q + ADDR_W'(PC_STEP);
    if (resp_drop) drop_cnt_d  = drop_cnt_q - CW'(1);
    // Everything still in flight after this cycle belongs to the abandoned stream.
    if (redirect) begin
      fetch_ptr_d = redirect_pc;
      drop_cnt_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_ptr_q   <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      started_q     <= 1'b0;
    end else begin
      fetch_ptr_q   <= fetch_ptr_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      started_q     <= started_d;
    end
  end

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (data_push),
    .push_data (data_in),
    .pop       (data_pop),
    .head      (data_head),
    .empty     (data_empty),
    .full      (data_full),
    .count     (data_count)
  );

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (issue),
    .push_data (fetch_ptr_q),
    .pop       (resp_keep),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (tag_count)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(data_push && data_full));
      assert (!(issue && tag_full));
      assert (!(resp_keep && tag_empty));
      assert (({1'b0, tag_count} + {1'b0, drop_cnt_q}) == {1'b0, outstanding_q});
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order IMEM responder and a pc scoreboard.
module tb_instr_fetch_queue;
  import cpu_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic               clk;
  logic               reset_n;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic               dec_ready;
  logic [CW-1:0]      q_count;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
    .q_count     (q_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_vec, n_err, n_xfer, n_grant, cyc, lat;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] pend_addr[$];
  int                pend_due[$];
  logic [ADDR_W-1:0] exp_fetch, prev_pc, first_pc;
  logic              last_dv, first_seen, wrap_seen;

  function automatic logic [INSTR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {6'b101101, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One clock: drive the due IMEM response, log grants, score transfers.
  task automatic cycle();
    logic [ADDR_W-1:0] e;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
    end
    if (redirect) begin
      exp_q.delete();
      exp_fetch = redirect_pc;
    end
    #1;
    last_dv = dec_valid;
    if (imem_req && imem_gnt) begin
      check("imem_addr", 32'(imem_addr), 32'(exp_fetch));
      exp_q.push_back(exp_fetch);
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      exp_fetch = exp_fetch + ADDR_W'(PC_STEP);
      n_grant++;
    end
    if (dec_valid && dec_ready) begin
      n_vec++;
      assert (exp_q.size() != 0)
        else begin
          n_err++;
          $error("FAIL xfer_extra observed_pc=%0h expected=none", dec_pc);
        end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("xfer_pc", 32'(dec_pc), 32'(e));
        check("xfer_instr", 32'(dec_instr), 32'(word_of(e)));
      end
      if (!first_seen) begin
        first_pc   = dec_pc;
        first_seen = 1'b1;
      end
      if (prev_pc == 10'h3FE && dec_pc == 10'h000) wrap_seen = 1'b1;
      prev_pc = dec_pc;
      n_xfer++;
    end
    @(posedge clk);
    cyc++;
    #1;
    imem_rvalid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] pc);
    logic rdy;
    rdy         = dec_ready;
    dec_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = pc;
    first_seen  = 1'b0;
    cycle();
    redirect    = 1'b0;
    dec_ready   = rdy;
  endtask

  task automatic drain(input string tag);
    imem_gnt  = 1'b0;
    dec_ready = 1'b1;
    run(10);
    check({tag, "_expq_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_qcount"}, 32'(q_count), 32'd0);
    check({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_xfer = 0; n_grant = 0; cyc = 0; lat = 1;
    exp_fetch = '0; prev_pc = '0; first_pc = '0;
    last_dv = 1'b0; first_seen = 1'b0; wrap_seen = 1'b0;
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b1;

    // reset state
    run(2);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_dec_pc", 32'(dec_pc), 32'd0);
    check("rst_dec_instr", 32'(dec_instr), 32'd0);
    reset_n = 1'b1;
    check("rel_req_delay", 32'(imem_req), 32'd0);
    cycle();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);

    // 1: streaming, no gaps once filled
    n_xfer = 0; n_grant = 0;
    cycle();
    check("t1_dv_before_rv", 32'(last_dv), 32'd0);
    cycle();
    check("t1_dv_at_rv", 32'(last_dv), 32'(BYP));
    run(10);
    check("t1_xfers", 32'(n_xfer), 32'(10 + BYP));
    check("t1_grants", 32'(n_grant), 32'd12);
    drain("t1");

    // 3: fetch pointer wrap
    imem_gnt = 1'b1;
    do_redirect(10'h3FC);
    run(8);
    check("t3_wrap_seen", 32'(wrap_seen), 32'd1);
    check("t3_first_pc", 32'(first_pc), 32'h3FC);
    drain("t3");

    // 4: two in flight at redirect, both dropped
    lat = 3; imem_gnt = 1'b1;
    run(2);
    do_redirect(10'h100);
    run(2);
    check("t4_dropped_q", 32'(q_count), 32'd0);
    check("t4_dropped_dv", 32'(dec_valid), 32'd0);
    run(8);
    drain("t4");
    check("t4_first_pc", 32'(first_pc), 32'h100);

    // 5: back-to-back redirects with responses in both cycles
    imem_gnt = 1'b1;
    run(3);
    do_redirect(10'h040);
    do_redirect(10'h080);
    cycle();
    check("t5_dropped_q", 32'(q_count), 32'd0);
    run(8);
    drain("t5");
    check("t5_first_pc", 32'(first_pc), 32'h080);

    // 2: decode stalled fills exactly DEPTH, then drains in order
    lat = 1; imem_gnt = 1'b1; dec_ready = 1'b0; n_grant = 0;
    run(8);
    check("t2_grants", 32'(n_grant), 32'd4);
    check("t2_q_full", 32'(q_count), 32'd4);
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_dv", 32'(dec_valid), 32'd1);
    check("t2_head_pc", 32'(dec_pc), 32'(exp_q[0]));
    dec_ready = 1'b1; n_xfer = 0; n_grant = 0;
    run(10);
    check("t2_xfers", 32'(n_xfer), 32'd10);
    check("t2_resume_grants", 32'(n_grant), 32'd9);
    drain("t2");

    // 6: reset with three words queued
    imem_gnt = 1'b1; dec_ready = 1'b0;
    run(4);
    check("t6_q3", 32'(q_count), 32'd3);
    reset_n = 1'b0; imem_gnt = 1'b0;
    #1;
    check("t6_rst_dv", 32'(dec_valid), 32'd0);
    check("t6_rst_q", 32'(q_count), 32'd0);
    check("t6_rst_req", 32'(imem_req), 32'd0);
    pend_addr.delete(); pend_due.delete(); exp_q.delete();
    exp_fetch = '0; first_seen = 1'b0;
    run(2);
    reset_n = 1'b1; imem_gnt = 1'b1; dec_ready = 1'b1;
    check("t6_rel_req", 32'(imem_req), 32'd0);
    cycle();
    check("t6_req", 32'(imem_req), 32'd1);
    check("t6_addr", 32'(imem_addr), 32'd0);
    run(6);
    drain("t6");
    check("t6_first_pc", 32'(first_pc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
